// File: rtl/multicycle_control_fsm_if.sv
// Instruction-fetch port of the multicycle control FSM.
//
// Handshake: the FSM (master) raises imem_req in FETCH and holds it high
// until imem_ready is seen high. The single cycle with imem_req and
// imem_ready both high is the transfer; ir_load marks that cycle so the
// external IR captures the word at the following posedge. ir is the IR
// contents and must stay stable until the instruction retires.
interface multicycle_control_fsm_if #(
    parameter int IR_W = 16
);
    logic            imem_req;
    logic            imem_ready;
    logic            ir_load;
    logic [IR_W-1:0] ir;

    modport master (
        output imem_req,
        output ir_load,
        input  imem_ready,
        input  ir
    );

    modport slave (
        input  imem_req,
        input  ir_load,
        output imem_ready,
        output ir
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle sequencer for the 16-bit, 4-register datapath.
// Steps each instruction through FETCH/DECODE/EXECUTE/WRITEBACK or BRANCH,
// drives every datapath enable, detects the all-ones halt word and counts
// retired instructions. Owns no datapath storage.
//
// Build option: define MCFSM_SINGLE_STEP_EN to make every retiring
// transition return to IDLE, so each instruction needs its own start pulse.
// Without it execution runs continuously until the halt word.
module multicycle_control_fsm #(
    parameter int IR_W  = 16,
    parameter int OP_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    multicycle_control_fsm_if.master imem,
    input  logic                     alu_zero,
    output logic                     pc_write,
    output logic                     pc_src,
    output logic                     reg_write,
    output logic                     reg_dst,
    output logic                     alu_src,
    output logic [3:0]               alu_control,
    output logic [2:0]               state,
    output logic                     busy,
    output logic                     halted,
    output logic [CNT_W-1:0]         instr_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_BRANCH    = 3'd5,
        S_HALT      = 3'd6
    } state_t;

`ifdef MCFSM_SINGLE_STEP_EN
    localparam state_t RETIRE_STATE = S_IDLE;
`else
    localparam state_t RETIRE_STATE = S_FETCH;
`endif

    localparam logic [OP_W-1:0] OP_BEQ     = OP_W'(10);
    localparam logic [OP_W-1:0] OP_BNE     = OP_W'(11);
    localparam logic [OP_W-1:0] OP_ALU_END = OP_W'(8);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;

    logic [OP_W-1:0]  w_op;
    logic             w_halt_word;
    logic             w_is_alu;
    logic             w_is_branch;
    logic             w_retire;

    logic [3:0]       w_dec_alu_control;
    logic             w_dec_alu_src;
    logic             w_dec_reg_dst;

    logic             w_imem_req;
    logic             w_ir_load;
    logic             w_pc_write;
    logic             w_pc_src;
    logic             w_reg_write;
    logic             w_reg_dst;
    logic             w_alu_src;
    logic [3:0]       w_alu_control;

    assign w_op        = imem.ir[IR_W-1 -: OP_W];
    assign w_halt_word = (imem.ir == {IR_W{1'b1}});
    assign w_is_alu    = (w_op < OP_ALU_END);
    assign w_is_branch = (w_op == OP_BEQ) || (w_op == OP_BNE);

    // State register; reset parks the sequencer in IDLE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Retired-instruction counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (w_retire) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // ALU control decode for R-type and addi (only meaningful for op < 8).
    always_comb begin
        w_dec_alu_control = 4'b0000;
        w_dec_alu_src     = 1'b0;
        w_dec_reg_dst     = 1'b1;
        case (w_op[2:0])
            3'd0: w_dec_alu_control = 4'b0010;
            3'd1: w_dec_alu_control = 4'b0110;
            3'd2: w_dec_alu_control = 4'b0000;
            3'd3: w_dec_alu_control = 4'b0001;
            3'd4: w_dec_alu_control = 4'b1100;
            3'd5: w_dec_alu_control = 4'b1101;
            3'd6: w_dec_alu_control = 4'b0111;
            default: begin
                w_dec_alu_control = 4'b0010;
                w_dec_alu_src     = 1'b1;
                w_dec_reg_dst     = 1'b0;
            end
        endcase
    end

    // Next-state and raw control outputs from the registered state.
    always_comb begin
        w_next        = r_state;
        w_retire      = 1'b0;
        w_imem_req    = 1'b0;
        w_ir_load     = 1'b0;
        w_pc_write    = 1'b0;
        w_pc_src      = 1'b0;
        w_reg_write   = 1'b0;
        w_reg_dst     = 1'b0;
        w_alu_src     = 1'b0;
        w_alu_control = 4'b0000;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (imem.imem_ready) begin
                    w_ir_load = 1'b1;
                    w_next    = S_DECODE;
                end
            end
            S_DECODE: begin
                // Halt word wins over the opcode field (its op is 1111).
                if (w_halt_word) begin
                    w_next = S_HALT;
                end else if (w_is_alu) begin
                    w_next = S_EXECUTE;
                end else if (w_is_branch) begin
                    w_next = S_BRANCH;
                end else begin
                    // Unassigned opcode: retire as a NOP straight from DECODE.
                    w_pc_write = 1'b1;
                    w_retire   = 1'b1;
                    w_next     = RETIRE_STATE;
                end
            end
            S_EXECUTE: begin
                w_alu_control = w_dec_alu_control;
                w_alu_src     = w_dec_alu_src;
                w_reg_dst     = w_dec_reg_dst;
                w_next        = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                w_alu_control = w_dec_alu_control;
                w_alu_src     = w_dec_alu_src;
                w_reg_dst     = w_dec_reg_dst;
                w_reg_write   = 1'b1;
                w_pc_write    = 1'b1;
                w_retire      = 1'b1;
                w_next        = RETIRE_STATE;
            end
            S_BRANCH: begin
                // Subtract to compare; beq takes on zero, bne on non-zero.
                w_alu_control = 4'b0110;
                w_pc_write    = 1'b1;
                w_pc_src      = ((w_op == OP_BEQ) &&  alu_zero) ||
                                ((w_op == OP_BNE) && !alu_zero);
                w_retire      = 1'b1;
                w_next        = RETIRE_STATE;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Outputs are forced low while reset is asserted, without waiting for a clock.
    always_comb begin
        imem.imem_req = reset_n & w_imem_req;
        imem.ir_load  = reset_n & w_ir_load;
        pc_write      = reset_n & w_pc_write;
        pc_src        = reset_n & w_pc_src;
        reg_write     = reset_n & w_reg_write;
        reg_dst       = reset_n & w_reg_dst;
        alu_src       = reset_n & w_alu_src;
        alu_control   = reset_n ? w_alu_control : 4'b0000;
        state         = reset_n ? r_state : 3'd0;
        busy          = reset_n & (r_state != S_IDLE) & (r_state != S_HALT);
        halted        = reset_n & (r_state == S_HALT);
        instr_count   = reset_n ? r_count : '0;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle sequencer for the 16-bit, 4-register datapath: register file, 16-bit ALU, branch-target adder and PC.
- Replaces the single-cycle combinational control and the free-running PC update.
- Steps each instruction through FETCH/DECODE/EXECUTE/WRITEBACK or BRANCH, handshakes with instruction memory, and detects the halt word.
- Drives every datapath enable; owns no datapath storage.

Parameters:
IR_W, 16, instruction width
OP_W, 4, opcode width (ir[IR_W-1 -: OP_W])
CNT_W, 16, retired-instruction counter width

Ports:
clock  in  1  system clock; all state updates on posedge
reset_n  in  1  asynchronous active-low reset
start  in  1  begin execution from IDLE; ignored in all other states
ir  in  IR_W  current instruction register contents (external IR, loaded by ir_load)
imem_req  out  1  instruction fetch request
imem_ready  in  1  fetch data valid this cycle
ir_load  out  1  load IR from instruction memory this cycle
alu_zero  in  1  zero flag from the execute ALU
pc_write  out  1  update PC at the next posedge
pc_src  out  1  0 = PC+2, 1 = branch target (PC+2 + sext(imm8)<<1)
reg_write  out  1  register file write enable
reg_dst  out  1  0 = write ir[9:8], 1 = write ir[7:6]
alu_src  out  1  0 = RD2, 1 = sext(ir[7:0])
alu_control  out  4  ALU op {ainvert, binvert, op[1:0]}
state  out  3  current state encoding
busy  out  1  state not IDLE and not HALT
halted  out  1  halt word retired
instr_count  out  CNT_W  retired instructions

Behaviour:
- Reset: state=IDLE (0); instr_count=0. All outputs 0 while reset_n low, including imem_req, reg_write and pc_write; they drop asynchronously mid-operation.
- State encodings: IDLE 0, FETCH 1, DECODE 2, EXECUTE 3, WRITEBACK 4, BRANCH 5, HALT 6.
- Output timing: outputs are combinational from the registered state, ir and alu_zero. Every output is 0 except where listed below.
- IDLE: start=1 -> FETCH.
- FETCH:
  - imem_req=1.
  - imem_ready=0: stay in FETCH, imem_req held high.
  - imem_ready=1: ir_load=1 for exactly that cycle, then -> DECODE.
- DECODE (op = ir[15:12]):
  - ir==16'hFFFF -> HALT. Checked before opcode decode.
  - op 0000-0111 -> EXECUTE.
  - op 1010/1011 -> BRANCH.
  - Any other op: treated as NOP. pc_write=1, pc_src=0, instr_count+1, -> FETCH.
- EXECUTE: alu_control, alu_src and reg_dst driven per the table below; -> WRITEBACK.
- WRITEBACK: same ALU controls held; reg_write=1 for exactly one cycle; pc_write=1, pc_src=0; instr_count+1; -> FETCH.
- BRANCH:
  - alu_control=0110, alu_src=0, pc_write=1.
  - pc_src = (op==1010 & alu_zero) | (op==1011 & ~alu_zero).
  - instr_count+1; -> FETCH.
- HALT: halted=1; terminal until reset_n low; start ignored; halt word not counted.
- Decode table (op: alu_control, alu_src, reg_dst):
  - add 0000: 0010, 0, 1
  - sub 0001: 0110, 0, 1
  - and 0010: 0000, 0, 1
  - or 0011: 0001, 0, 1
  - nor 0100: 1100, 0, 1
  - nand 0101: 1101, 0, 1
  - slt 0110: 0111, 0, 1
  - addi 0111: 0010, 1, 0
- Latency with imem_ready tied high:
  - R-type/addi: 4 cycles per instruction.
  - Branch: 3 cycles per instruction.
  - NOP: 2 cycles per instruction.
- instr_count: wraps 2^CNT_W-1 -> 0.
- Write-to-register-0 suppression stays in the register file; the FSM asserts reg_write regardless of destination.
- ir must be stable from DECODE until the instruction retires; ir_load is asserted only in FETCH.

Optional Feature:
- Macro: MCFSM_SINGLE_STEP_EN.
- Defined: each retiring transition (WRITEBACK, BRANCH, NOP exit from DECODE) goes to IDLE instead of FETCH. The retiring cycle still drives pc_write. Each further instruction requires a new start pulse.
- Not defined: retiring transitions go directly to FETCH and execution is continuous until HALT.

Test Plan:
1. Reset, start=1, ir=0111_00_01_00001111 (addi), imem_ready=1 -> state 1,2,3,4,1.
   - alu_src=1, reg_dst=0, alu_control=0010 in states 3-4.
   - reg_write high exactly 1 cycle (state 4), with pc_write=1, pc_src=0.
   - instr_count=1.
2. imem_ready low for 3 cycles in FETCH, then high -> imem_req high 4 consecutive cycles; ir_load high only on the 4th; DECODE follows.
3. Branches (each -> reg_write never 1; instr_count+1 each):
   - ir=1011_01_10_11111100 (bne), alu_zero=0 -> BRANCH with alu_control=0110, pc_write=1, pc_src=1.
   - Same ir, alu_zero=1 -> pc_src=0.
   - ir=1010_xxxx (beq), alu_zero=1 -> pc_src=1.
4. Sweep ops 0000-0110 -> alu_control in EXECUTE = 0010, 0110, 0000, 0001, 1100, 1101, 0111; reg_dst=1, alu_src=0 each.
5. ir=16'hFFFF -> DECODE then HALT (6): halted=1, busy=0, start pulses ignored, instr_count unchanged. reset_n low -> state 0, halted=0, count 0.
6. ir=0001_01_10_11_000000 (sub), reset_n low during EXECUTE -> outputs 0 immediately, before any clock edge; no reg_write pulse. Separately, op 1000 -> NOP: pc_write=1 in DECODE, count+1.
